io_terminal: RTL and testbench
==============================

// Module: io_terminal
// PURPOSE
// Peripheral end of the Basic Computer's programmed-I/O interface (INPR/FGI, OUTR/FGO).
// Receives OUT characters from the CPU, buffers them and streams them to a display sink.
// Accepts keyboard bytes from a source, buffers them and presents them one at a time in INPR/FGI.
// Sits beside DataPath and is instantiated with it in the top-level bench.
// PARAMETERS
// OUT_DEPTH   4   output FIFO entries (power of 2, >=2)
// IN_DEPTH    4   input FIFO entries (power of 2, >=2)
// BUSY_CYCLES 3   cycles FGO stays low after an accepted OUT (>=1)
// PORTS
// clk         in   1  system clock, rising edge
// reset       in   1  asynchronous, active-low reset
// Enable      in   1  1 = block operates; 0 = all state frozen, strobes ignored
// outr        in   8  CPU OUTR value, sampled on out_strobe
// out_strobe  in   1  one-cycle pulse: CPU executed OUT
// fgo         out  1  output flag: 1 = ready for next OUT
// inpr        out  8  input character register
// fgi         out  1  input flag: 1 = inpr holds an unread char
// inp_ack     in   1  one-cycle pulse: CPU executed INP (consumes inpr)
// tx_data     out  8  display byte (head of output FIFO)
// tx_valid    out  1  output FIFO non-empty
// tx_ready    in   1  sink accepts tx_data when tx_valid & tx_ready
// rx_data     in   8  keyboard byte
// rx_valid    in   1  source offers rx_data
// rx_ready    out  1  input FIFO not full
// out_err     out  1  sticky: out_strobe seen while fgo=0
// BEHAVIOUR
// Reset (reset=0, async): fgo=1, fgi=0, inpr=0, out_err=0, both FIFOs empty, tx_valid=0, rx_ready=1, FSM=READY.
// Enable=0: no FIFO push/pop, no counter/flag change; outputs hold; rx_ready and tx_valid forced 0.
// Output-flag FSM (all transitions on rising clk, Enable=1):
//  READY: fgo=1. out_strobe -> push outr, counter=BUSY_CYCLES-1, go BUSY.
//  BUSY: fgo=0. counter decrements; at 0 go READY if FIFO not full, else STALL.
//  STALL: fgo=0; go READY the cycle after a tx pop makes room.
// out_strobe while fgo=0: data dropped, out_err<=1 (cleared only by reset).
// Accepted OUT -> fgo low next edge, stays low exactly BUSY_CYCLES cycles when FIFO has room.
// tx side: tx_data = FIFO head, combinational from storage; pop on tx_valid&tx_ready.
// Push and pop in the same cycle both take effect; occupancy unchanged.
// Input path: push rx_data on rx_valid&rx_ready. When fgi=0 and input FIFO non-empty:
//  pop head into inpr, fgi<=1 on the same edge (1-cycle latency from byte in FIFO).
// inp_ack with fgi=1: fgi<=0; inpr keeps its value; next byte loads no earlier than the following edge.
// inp_ack with fgi=0: ignored. rx push and inpr load in same cycle allowed (full-depth stream).
// FIFO pointers are log2(depth)+1 bits; wrap by natural overflow; full = MSBs differ, low bits equal.
// Reset asserted mid-transfer: all buffered data discarded, no partial tx/rx beat.
// TESTING
// 1 Reset: reset=0 at t=0 -> fgo=1, fgi=0, tx_valid=0, rx_ready=1, out_err=0.
// 2 OUT 0x41, tx_ready=1 -> tx_data=0x41 tx_valid=1 one cycle; fgo low 3 cycles, then 1.
// 3 tx_ready=0, 5 OUTs 0x30..0x34 each when fgo=1 -> 4 stored, FSM STALL, fgo=0;
//   raise tx_ready -> bytes 0x30..0x33 in order, fgo=1 after first pop.
// 4 out_strobe while fgo=0 with outr=0x7F -> 0x7F never on tx_data, out_err=1.
// 5 rx bytes 0x10,0x11,0x12 back-to-back -> inpr=0x10 fgi=1; inp_ack -> fgi=0,
//   next edge inpr=0x11 fgi=1; repeat for 0x12; 5 bytes with no ack -> rx_ready=0 after 4 queued + 1 in inpr.
// 6 Enable=0 mid-stream with pending data -> tx_valid=0, rx_ready=0, fgo/fgi/inpr unchanged; Enable=1 resumes in order.

Source files
------------

// File: rtl/io_terminal.sv
// io_terminal: peripheral side of the programmed-I/O interface.
// OUT bytes are buffered toward a display sink. Keyboard bytes are buffered and
// handed to the CPU one at a time through inpr/fgi.
module io_terminal #(
  parameter int OUT_DEPTH   = 4,
  parameter int IN_DEPTH    = 4,
  parameter int BUSY_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Enable,
  input  logic [7:0] outr,
  input  logic       out_strobe,
  output logic       fgo,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       inp_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       out_err
);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int CW  = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [1:0] {READY, BUSY, STALL} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // Output FIFO: extra pointer MSB distinguishes full from empty
  logic [7:0]   omem [OUT_DEPTH];
  logic [OAW:0] owp, orp;
  logic         o_full, o_empty, o_push, o_pop;

  // Input FIFO
  logic [7:0]   imem [IN_DEPTH];
  logic [IAW:0] iwp, irp;
  logic         i_full, i_empty, i_push, i_load, i_ack;

  assign o_full  = (owp[OAW] != orp[OAW]) && (owp[OAW-1:0] == orp[OAW-1:0]);
  assign o_empty = (owp == orp);
  assign i_full  = (iwp[IAW] != irp[IAW]) && (iwp[IAW-1:0] == irp[IAW-1:0]);
  assign i_empty = (iwp == irp);

  // Handshakes go quiet while disabled so nothing moves
  assign fgo      = (state == READY);
  assign tx_valid = Enable && !o_empty;
  assign tx_data  = omem[orp[OAW-1:0]];
  assign rx_ready = Enable && !i_full;

  assign o_push = Enable && out_strobe && (state == READY);
  assign o_pop  = tx_valid && tx_ready;
  assign i_push = rx_valid && rx_ready;
  assign i_load = Enable && !fgi && !i_empty;
  assign i_ack  = Enable && inp_ack && fgi;

  // Output-flag next state: busy window after each OUT, then wait for room
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      READY: if (out_strobe) begin
        state_n = BUSY;
        cnt_n   = CW'(BUSY_CYCLES - 1);
      end
      BUSY: if (cnt == '0) state_n = o_full ? STALL : READY;
            else           cnt_n   = cnt - 1'b1;
      STALL: if (o_pop || !o_full) state_n = READY;
      default: state_n = READY;
    endcase
  end

  // Flag FSM, output pointers and sticky error; frozen when disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= READY;
      cnt     <= '0;
      owp     <= '0;
      orp     <= '0;
      out_err <= 1'b0;
    end else if (Enable) begin
      state <= state_n;
      cnt   <= cnt_n;
      if (o_push) owp <= owp + 1'b1;
      if (o_pop)  orp <= orp + 1'b1;
      if (out_strobe && state != READY) out_err <= 1'b1;
    end
  end

  // Output FIFO storage (no reset needed, pointers define validity)
  always_ff @(posedge clk) begin
    if (o_push) omem[owp[OAW-1:0]] <= outr;
  end

  // Input pointers and INPR/FGI: load head as soon as inpr is free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iwp  <= '0;
      irp  <= '0;
      inpr <= '0;
      fgi  <= 1'b0;
    end else begin
      if (i_push) iwp <= iwp + 1'b1;
      if (i_load) begin
        irp  <= irp + 1'b1;
        inpr <= imem[irp[IAW-1:0]];
        fgi  <= 1'b1;
      end else if (i_ack) begin
        fgi <= 1'b0;
      end
    end
  end

  // Input FIFO storage
  always_ff @(posedge clk) begin
    if (i_push) imem[iwp[IAW-1:0]] <= rx_data;
  end
endmodule

// File: tb/tb_io_terminal.sv
// Randomized bench for io_terminal against a queue-based reference model.
module tb_io_terminal;
  localparam int OD = 4, ID = 4, BC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Enable = 1'b0;
  logic [7:0] outr = '0;
  logic       out_strobe = 1'b0;
  logic       fgo, fgi, tx_valid, rx_ready, out_err;
  logic [7:0] inpr, tx_data;
  logic       inp_ack = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;

  io_terminal #(.OUT_DEPTH(OD), .IN_DEPTH(ID), .BUSY_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .outr(outr), .out_strobe(out_strobe),
    .fgo(fgo), .inpr(inpr), .fgi(fgi), .inp_ack(inp_ack), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got %0h exp %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: byte queues plus the fgo low window measured in cycles
  logic [7:0] oq[$];
  logic [7:0] iq[$];
  int         low_left;   // cycles of fgo=0 still owed after an accepted OUT
  bit         need_room;  // window ended with FIFO full; wait for space
  bit         m_fgi, m_err;
  logic [7:0] m_inpr;

  function automatic bit m_fgo();
    return (low_left == 0) && !need_room;
  endfunction

  task automatic model_reset();
    oq.delete(); iq.delete();
    low_left = 0; need_room = 0; m_fgi = 0; m_err = 0; m_inpr = '0;
  endtask

  // One cycle: drive inputs, check outputs, advance model to the next edge
  task automatic cyc(input bit en, input bit stb, input logic [7:0] o, input bit ack,
                     input bit txr, input bit rxv, input logic [7:0] rxd);
    bit pop, acc, rpush, load, f;
    @(negedge clk);
    Enable = en; out_strobe = stb; outr = o; inp_ack = ack;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #1;
    f = m_fgo();
    chk("fgo", fgo, f);
    chk("fgi", fgi, m_fgi);
    chk("inpr", inpr, m_inpr);
    chk("out_err", out_err, m_err);
    chk("tx_valid", tx_valid, en && oq.size() > 0);
    if (en && oq.size() > 0) chk("tx_data", tx_data, oq[0]);
    chk("rx_ready", rx_ready, en && iq.size() < ID);
    if (!en) return;
    pop   = txr && oq.size() > 0;
    acc   = stb && f;
    rpush = rxv && iq.size() < ID;
    load  = !m_fgi && iq.size() > 0;
    if (stb && !f) m_err = 1;
    if (need_room) begin
      if (pop || oq.size() < OD) need_room = 0;
    end else if (low_left > 0) begin
      if (low_left == 1 && oq.size() == OD) need_room = 1;
      low_left--;
    end else if (acc) begin
      low_left = BC;
    end
    if (pop) void'(oq.pop_front());
    if (acc) oq.push_back(o);
    if (ack && m_fgi) m_fgi = 0;
    if (load) begin m_inpr = iq.pop_front(); m_fgi = 1; end
    if (rpush) iq.push_back(rxd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; Enable = 1'b0; out_strobe = 1'b0; inp_ack = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_fgo", fgo, 1);
    chk("rst_fgi", fgi, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_out_err", out_err, 0);
    reset = 1'b1;
  endtask

  function automatic bit pr(int p);
    return $urandom_range(99) < p;
  endfunction

  // Random segment; strict mode only strobes OUT when the model says fgo=1
  task automatic run(int n, int p_en, int p_stb, int p_ack, int p_txr, int p_rxv, bit strict);
    bit stb;
    for (int i = 0; i < n; i++) begin
      stb = pr(p_stb);
      if (strict && !m_fgo()) stb = 0;
      cyc(pr(p_en), stb, 8'($urandom), pr(p_ack), pr(p_txr), pr(p_rxv), 8'($urandom));
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("t0_fgo", fgo, 1);
    chk("t0_fgi", fgi, 0);
    chk("t0_tx_valid", tx_valid, 0);
    chk("t0_out_err", out_err, 0);
    Enable = 1'b1;
    #1 chk("t0_rx_ready", rx_ready, 1);
    Enable = 1'b0;
    reset = 1'b1;

    // Single OUT with sink ready, then idle to watch the busy window
    cyc(1, 1, 8'h41, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    // Fill output FIFO with sink stalled, then drain
    for (int i = 0; i < 30; i++) cyc(1, m_fgo(), 8'(8'h30 + oq.size()), 0, 0, 0, 0);
    cyc(1, 1, 8'h7F, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    // Back-to-back rx bytes, acks, then overfill the input side
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, (i % 2) == 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 1, 8'(8'h20 + i));
    // Freeze with data pending, then resume
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h55, 1, 1, 1, 8'h66);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 1, 0, 0);

    do_reset();
    run(400, 100, 60, 40, 50, 60, 1);
    do_reset();
    run(400, 100, 80, 10, 15, 90, 1);   // pushes both FIFOs to full
    run(300, 60, 50, 40, 50, 50, 1);    // Enable toggling
    do_reset();
    run(300, 90, 50, 40, 40, 50, 0);    // strobes during busy -> sticky error
    do_reset();                         // reset with buffered data
    run(200, 100, 60, 50, 60, 60, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
